// File: rtl/hex_mode_ctrl_pkg.sv
// Shared types and helpers for the display mode controller.
// Contents: disp_mode_t (WATCH/TIMER/ALARM) and cnt_w(), which returns the
// counter width needed to hold the values 0..n-1 (at least 1 bit).
package hex_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_WATCH = 2'd0,
    MODE_TIMER = 2'd1,
    MODE_ALARM = 2'd2
  } disp_mode_t;

  // Width of a counter that holds 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_mode_ctrl_if.sv
// Signal bundle between the display mode controller and its surroundings.
//   key_mode_n  raw mode key, active-low, asynchronous
//   timer_run   countdown timer running (level)
//   timer_done  countdown reached zero (1-cycle pulse)
//   dsp_Hex     1 = watch digits, 0 = timer digits
//   hex_blank   per-digit blank request, 1 = digit off
//   mode        current display mode (disp_mode_t encoding)
//   alarm       high while in ALARM
// The slave modport is the controller; the master modport is the system side.
interface hex_mode_ctrl_if;

  logic       key_mode_n;
  logic       timer_run;
  logic       timer_done;
  logic       dsp_Hex;
  logic [3:0] hex_blank;
  logic [1:0] mode;
  logic       alarm;

  modport master (
    output key_mode_n, timer_run, timer_done,
    input  dsp_Hex, hex_blank, mode, alarm
  );

  modport slave (
    input  key_mode_n, timer_run, timer_done,
    output dsp_Hex, hex_blank, mode, alarm
  );

endinterface

// File: rtl/hex_mode_ctrl_key_debounce.sv
// Key synchroniser and debouncer producing a 1-cycle press pulse.
//   clk, rst  clock, asynchronous active-high reset
//   key_n     raw key, active-low, asynchronous to clk
//   press     1-cycle pulse on the debounced released->pressed edge
// The debounced level follows the synchronised key only after it has
// disagreed for DB_CYCLES consecutive cycles; release makes no pulse.
module key_debounce
  import hex_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned DB_W = cnt_w(DB_CYCLES);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Synchroniser shift, debounce counter and press edge detect.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
      cnt_d   = '0;
      db_d    = sync2_q;
      press_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/hex_mode_ctrl.sv
// Seven-segment display mode controller: chooses watch or timer digits.
//   clk, rst  clock, asynchronous active-high reset
//   bus       hex_mode_ctrl_if.slave (key, timer status in; dsp_Hex,
//             hex_blank, mode, alarm out; all outputs registered)
// Holds the 1 s prescaler, the TIMER idle counter and the WATCH/TIMER/ALARM
// FSM. Optional macro HEX_BLINK_EN adds BLINK_DIV and blinks all digits
// while in ALARM; without it hex_blank is constant 4'b0000.
module hex_mode_ctrl
  import hex_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_S = 10
`ifdef HEX_BLINK_EN
  , parameter int unsigned BLINK_DIV = 12_500_000
`endif
) (
  input  logic           clk,
  input  logic           rst,
  hex_mode_ctrl_if.slave bus
);

  localparam int unsigned PRESC_W = cnt_w(CLK_HZ);
  localparam int unsigned IDLE_W  = cnt_w(TIMEOUT_S);

  localparam logic [1:0] ST_WATCH = 2'(MODE_WATCH);
  localparam logic [1:0] ST_TIMER = 2'(MODE_TIMER);
  localparam logic [1:0] ST_ALARM = 2'(MODE_ALARM);

  logic               press;
  logic               sec_tick;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [1:0]         state_q, state_d;
  logic               dsp_hex_q, dsp_hex_d;
  logic [1:0]         mode_q, mode_d;
  logic               alarm_q, alarm_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key_mode_n),
    .press (press)
  );

  // Free-running prescaler; sec_tick marks its wrap.
  always_comb begin
    sec_tick = (presc_q == PRESC_W'(CLK_HZ - 1));
    presc_d  = sec_tick ? '0 : presc_q + PRESC_W'(1);
  end

  // Next-state, idle counter and registered-output values.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    case (state_q)
      ST_WATCH: begin
        if (bus.timer_done)  state_d = ST_ALARM;
        else if (press)      state_d = ST_TIMER;
      end
      ST_TIMER: begin
        if (bus.timer_done)  state_d = ST_ALARM;
        else if (press)      state_d = ST_WATCH;
        else if (idle_q == IDLE_W'(TIMEOUT_S - 1) && sec_tick && !bus.timer_run)
          state_d = ST_WATCH;
      end
      ST_ALARM: begin
        if (press)           state_d = ST_WATCH;
      end
      default:               state_d = ST_WATCH;
    endcase

    // Idle seconds only accumulate while staying in TIMER with the timer stopped.
    if (state_q != ST_TIMER || state_d != ST_TIMER || press || bus.timer_run)
      idle_d = '0;
    else if (sec_tick && idle_q != IDLE_W'(TIMEOUT_S - 1))
      idle_d = idle_q + IDLE_W'(1);

    // Outputs follow the next state so they update on the same edge as state.
    dsp_hex_d = (state_d == ST_WATCH);
    mode_d    = state_d;
    alarm_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      idle_q    <= '0;
      state_q   <= ST_WATCH;
      dsp_hex_q <= 1'b1;
      mode_q    <= ST_WATCH;
      alarm_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idle_q    <= idle_d;
      state_q   <= state_d;
      dsp_hex_q <= dsp_hex_d;
      mode_q    <= mode_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.dsp_Hex = dsp_hex_q;
  assign bus.mode    = mode_q;
  assign bus.alarm   = alarm_q;

`ifdef HEX_BLINK_EN
  localparam int unsigned BLINK_W = cnt_w(BLINK_DIV);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [3:0]         blank_q, blank_d;

  // Visible on ALARM entry, then toggles every BLINK_DIV cycles; dark only in ALARM.
  always_comb begin
    blink_cnt_d = '0;
    blank_d     = 4'b0000;
    if (state_d == ST_ALARM && state_q == ST_ALARM) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blank_d     = blank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 4'b0000;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign bus.hex_blank = blank_q;
`else
  assign bus.hex_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_hex_mode_ctrl.sv
// Randomised self-checking bench for hex_mode_ctrl against a behavioural model.
module tb_hex_mode_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int DB_CYCLES = 4;
  localparam int TIMEOUT_S = 3;
`ifdef HEX_BLINK_EN
  localparam int BLINK_DIV = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  hex_mode_ctrl_if bus ();

  hex_mode_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .DB_CYCLES (DB_CYCLES),
    .TIMEOUT_S (TIMEOUT_S)
`ifdef HEX_BLINK_EN
    , .BLINK_DIV (BLINK_DIV)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: 0=WATCH 1=TIMER 2=ALARM.
  int m_cyc;     // edges since reset release (prescaler phase)
  bit m_s1, m_s2;
  bit m_db;      // debounced key level, 1 = released
  int m_run;     // consecutive edges synced key disagreed with debounced level
  bit m_press;
  int m_mode;
  int m_idle;    // seconds idle in TIMER, saturating
  int m_age;     // cycles since ALARM entry

  task automatic model_reset();
    m_cyc = 0; m_s1 = 1; m_s2 = 1; m_db = 1; m_run = 0; m_press = 0;
    m_mode = 0; m_idle = 0; m_age = 0;
  endtask

  task automatic model_edge(input bit k, input bit trun, input bit tdone);
    bit tick;
    int nmode;
    bit npress;
    tick  = (m_cyc % CLK_HZ) == CLK_HZ - 1;
    nmode = m_mode;
    case (m_mode)
      0: if (tdone) nmode = 2; else if (m_press) nmode = 1;
      1: if (tdone) nmode = 2; else if (m_press) nmode = 0;
         else if (m_idle == TIMEOUT_S - 1 && tick && !trun) nmode = 0;
      default: if (m_press) nmode = 0;
    endcase
    if (!(m_mode == 1 && nmode == 1) || trun) m_idle = 0;
    else if (tick && m_idle < TIMEOUT_S - 1) m_idle++;
    m_age  = (nmode == 2 && m_mode == 2) ? m_age + 1 : 0;
    npress = 0;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DB_CYCLES) begin
        m_db = m_s2; m_run = 0; npress = (m_db == 0);
      end
    end else m_run = 0;
    m_press = npress;
    m_s2 = m_s1; m_s1 = k;
    m_mode = nmode;
    m_cyc++;
  endtask

  function automatic logic [3:0] exp_blank();
`ifdef HEX_BLINK_EN
    return (m_mode == 2 && ((m_age / BLINK_DIV) % 2) == 1) ? 4'hF : 4'h0;
`else
    return 4'h0;
`endif
  endfunction

  // One clock: drive at negedge, model on posedge, compare just after.
  task automatic cycle(input bit k, input bit trun, input bit tdone);
    bus.key_mode_n = k; bus.timer_run = trun; bus.timer_done = tdone;
    @(posedge clk);
    model_edge(k, trun, tdone);
    #1;
    check("dsp_Hex",   32'(bus.dsp_Hex),   32'(m_mode == 0));
    check("mode",      32'(bus.mode),      32'(m_mode));
    check("alarm",     32'(bus.alarm),     32'(m_mode == 2));
    check("hex_blank", 32'(bus.hex_blank), 32'(exp_blank()));
    @(negedge clk);
    bus.timer_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dsp"},   32'(bus.dsp_Hex),   32'd1);
    check({tag, "_mode"},  32'(bus.mode),      32'd0);
    check({tag, "_alarm"}, 32'(bus.alarm),     32'd0);
    check({tag, "_blank"}, 32'(bus.hex_blank), 32'd0);
  endtask

  logic [3:0] blank_seq [5];
  logic [3:0] blank_exp [5];

  initial begin
    int lat;
    int elapsed;
    bit trun;
    int lo, hi;

    bus.key_mode_n = 1'b1; bus.timer_run = 1'b0; bus.timer_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    model_reset();

    // Short bounce must not produce a press.
    cycle(0, 0, 0); cycle(0, 0, 0);
    repeat (10) cycle(1, 0, 0);
    check("bounce_no_press", 32'(bus.dsp_Hex), 32'd1);

    // Clean press: dsp_Hex drops 7 cycles after the key edge.
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 0);
      if (lat == 0 && bus.dsp_Hex == 1'b0) lat = i;
    end
    check("press_latency", 32'(lat), 32'd7);
    check("mode_timer", 32'(bus.mode), 32'd1);

    // Idle timeout back to WATCH.
    elapsed = 3;
    for (int i = 0; i < 200; i++) begin
      cycle(1, 0, 0);
      elapsed++;
      if (bus.dsp_Hex == 1'b1) break;
    end
    check("timeout_window",
          32'(elapsed > (TIMEOUT_S - 1) * CLK_HZ && elapsed <= (TIMEOUT_S + 1) * CLK_HZ), 32'd1);

    // Running timer holds TIMER view.
    repeat (10) cycle(0, 1, 0);
    check("enter_timer_run", 32'(bus.mode), 32'd1);
    repeat (100) cycle(1, 1, 0);
    check("run_hold_timer", 32'(bus.mode), 32'd1);
    repeat (10) cycle(0, 0, 0);
    check("timer_press_exit", 32'(bus.mode), 32'd0);
    repeat (10) cycle(1, 0, 0);

    // timer_done wins over a simultaneous press in WATCH.
    repeat (6) cycle(0, 0, 0);
    cycle(0, 0, 1);
    check("done_prio_alarm", 32'(bus.alarm), 32'd1);
    check("done_prio_dsp", 32'(bus.dsp_Hex), 32'd0);
    blank_seq[0] = bus.hex_blank;
    for (int i = 1; i < 5; i++) begin
      cycle(1, 0, 0);
      blank_seq[i] = bus.hex_blank;
    end
`ifdef HEX_BLINK_EN
    blank_exp[0] = 4'h0; blank_exp[1] = 4'h0; blank_exp[2] = 4'hF;
    blank_exp[3] = 4'hF; blank_exp[4] = 4'h0;
`else
    for (int i = 0; i < 5; i++) blank_exp[i] = 4'h0;
`endif
    for (int i = 0; i < 5; i++) check("blink_seq", 32'(blank_seq[i]), 32'(blank_exp[i]));
    repeat (12) cycle(1, 0, 1);
    check("alarm_ignores_done", 32'(bus.mode), 32'd2);
    repeat (10) cycle(0, 0, 0);
    check("alarm_press_exit", 32'(bus.mode), 32'd0);
    repeat (10) cycle(1, 0, 0);

    // Asynchronous reset in the middle of ALARM.
    cycle(1, 0, 1);
    check("alarm_again", 32'(bus.alarm), 32'd1);
    repeat (3) cycle(1, 0, 0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Random key bursts, timer status and done pulses.
    for (int b = 0; b < 150; b++) begin
      trun = ($urandom_range(0, 3) == 0);
      lo = $urandom_range(1, 12);
      hi = $urandom_range(1, 30);
      for (int i = 0; i < lo; i++) cycle(0, trun, ($urandom_range(0, 29) == 0));
      for (int i = 0; i < hi; i++) cycle(1, trun, ($urandom_range(0, 29) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
